// File: rtl/rom_dump_sequencer_pkg.sv
// Shared definitions for the ROM reader socket: FSM states, chip codes, default depths
// and the idle (deasserted) levels of the active-low chip-select buses.
package rom_reader_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_EMIT    = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  localparam logic CHIP_IP3601 = 1'b0;
  localparam logic CHIP_IP3604 = 1'b1;

  localparam int unsigned DEFAULT_IP3601_DEPTH  = 256;
  localparam int unsigned DEFAULT_IP3604_DEPTH  = 512;
  localparam int unsigned DEFAULT_ACCESS_CYCLES = 4;

  localparam logic [1:0] SEL3601_IDLE = 2'b11;
  localparam logic [3:0] SEL3604_IDLE = 4'b1111;

endpackage

// File: rtl/rom_access_timer.sv
// Loadable down-counter that times the ROM access window; expired_o is high once the
// count reaches zero, so a load of CYCLES-1 followed by ticks gives exactly CYCLES cycles.
module rom_access_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(CYCLES - 1);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Automatic ROM dump: walks every address of the latched chip, captures each byte after the
// access time and offers it downstream over valid/ready while keeping a mod-256 checksum.
module rom_dump_sequencer
  import rom_reader_defs::*;
#(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IP3601_DEPTH  = DEFAULT_IP3601_DEPTH,
  parameter int unsigned IP3604_DEPTH  = DEFAULT_IP3604_DEPTH,
  parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_button,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  chip_type,
  input  logic [DATA_WIDTH-1:0] chip_data_port,
  output logic [ADDR_WIDTH-1:0] chip_address_port,
  output logic [1:0]            ip3601_selection_port,
  output logic [3:0]            ip3604_selection_port,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic [ADDR_WIDTH-1:0] byte_address,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_3601 = ADDR_WIDTH'(IP3601_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_3604 = ADDR_WIDTH'(IP3604_DEPTH - 1);

  state_e                state_q, state_d;
  logic                  chip_q, chip_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            sel01_q, sel01_d;
  logic [3:0]            sel04_q, sel04_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  logic tmr_load, tmr_tick, tmr_expired;
  logic last_addr, sel_on;

  rom_access_timer #(
    .CYCLES (ACCESS_CYCLES)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset_button),
    .load_i    (tmr_load),
    .tick_i    (tmr_tick),
    .expired_o (tmr_expired)
  );

  assign last_addr = (addr_q == ((chip_q == CHIP_IP3604) ? LAST_3604 : LAST_3601));

  always_comb begin
    state_d  = state_q;
    chip_d   = chip_q;
    addr_d   = addr_q;
    data_d   = data_q;
    baddr_d  = baddr_q;
    valid_d  = valid_q;
    csum_d   = csum_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    sel_on   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          chip_d  = chip_type;
          addr_d  = '0;
          csum_d  = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        addr_d   = '0;
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expired) state_d = ST_CAPTURE;
        else             tmr_tick = 1'b1;
      end
      ST_CAPTURE: begin
        data_d  = chip_data_port;
        baddr_d = addr_q;
        state_d = ST_EMIT;
      end
      // First EMIT cycle raises valid; the handshake is evaluated from then on.
      ST_EMIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (byte_ready) begin
          valid_d = 1'b0;
          csum_d  = csum_q + data_q;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_addr) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    // Outputs are decoded from the next state so each register reflects the state it enters.
    sel_on  = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    sel01_d = (sel_on && (chip_d == CHIP_IP3601)) ? 2'b00 : SEL3601_IDLE;
    sel04_d = (sel_on && (chip_d == CHIP_IP3604)) ? 4'b0000 : SEL3604_IDLE;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q <= ST_IDLE;
      chip_q  <= CHIP_IP3601;
      addr_q  <= '0;
      sel01_q <= SEL3601_IDLE;
      sel04_q <= SEL3604_IDLE;
      data_q  <= '0;
      baddr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      addr_q  <= addr_d;
      sel01_q <= sel01_d;
      sel04_q <= sel04_d;
      data_q  <= data_d;
      baddr_q <= baddr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csum_q  <= csum_d;
    end
  end

  assign chip_address_port     = addr_q;
  assign ip3601_selection_port = sel01_q;
  assign ip3604_selection_port = sel04_q;
  assign byte_data             = data_q;
  assign byte_address          = baddr_q;
  assign byte_valid            = valid_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign checksum              = csum_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Directed bench for rom_dump_sequencer; the socket model returns addr[7:0]^8'h5A.
module tb_rom_dump_sequencer;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int AC = 4;

  logic          clk = 1'b0;
  logic          reset_button, start, abort, chip_type, byte_ready;
  logic [DW-1:0] chip_data_port, byte_data, checksum;
  logic [AW-1:0] chip_address_port, byte_address;
  logic [1:0]    ip3601_selection_port;
  logic [3:0]    ip3604_selection_port;
  logic          byte_valid, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign chip_data_port = chip_address_port[7:0] ^ 8'h5A;

  rom_dump_sequencer #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .IP3601_DEPTH  (256),
    .IP3604_DEPTH  (512),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clk                   (clk),
    .reset_button          (reset_button),
    .start                 (start),
    .abort                 (abort),
    .chip_type             (chip_type),
    .chip_data_port        (chip_data_port),
    .chip_address_port     (chip_address_port),
    .ip3601_selection_port (ip3601_selection_port),
    .ip3604_selection_port (ip3604_selection_port),
    .byte_data             (byte_data),
    .byte_address          (byte_address),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .busy                  (busy),
    .done                  (done),
    .checksum              (checksum)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_sum(input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int a = 0; a < n; a++) s = s + (8'(a) ^ 8'h5A);
    return s;
  endfunction

  // Advances until address a is being handed over (valid && ready visible this cycle).
  task automatic wait_xfer(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (byte_valid && byte_ready && (byte_address == AW'(a))) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_button = 1'b0; start = 1'b0; abort = 1'b0; chip_type = 1'b0; byte_ready = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, byte_valid, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: busy/valid/done=%b expected 000", {busy, byte_valid, done});
    end
    checks++;
    if ({checksum, byte_data, byte_address} !== 25'd0) begin
      errors++; $display("FAIL reset_data: csum=%h data=%h baddr=%h expected zeros", checksum, byte_data, byte_address);
    end
    checks++;
    if ({chip_address_port, ip3601_selection_port, ip3604_selection_port} !== {9'd0, 2'b11, 4'b1111}) begin
      errors++; $display("FAIL reset_pins: addr=%h s01=%b s04=%b expected 0/11/1111",
                         chip_address_port, ip3601_selection_port, ip3604_selection_port);
    end
    reset_button = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_dump(input logic ct);
    int depth, n, dones, cyc, bad, bad_sel, rise0, rise1, last_a;
    logic [7:0] sum;
    logic pv;
    logic [1:0] s01_on;
    logic [3:0] s04_on;
    depth = ct ? 512 : 256;
    n = 0; dones = 0; cyc = 0; bad = 0; bad_sel = 0; rise0 = -1; rise1 = -1; last_a = -1;
    sum = 8'h00; pv = 1'b0;
    s01_on = ct ? 2'b11 : 2'b00;
    s04_on = ct ? 4'b0000 : 4'b1111;
    chip_type = ct; byte_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chip_type = ~ct;
    while (cyc < 6000) begin
      if (byte_valid && !pv) begin
        if (rise0 < 0) rise0 = cyc;
        else if (rise1 < 0) rise1 = cyc;
      end
      pv = byte_valid;
      if (byte_valid && byte_ready) begin
        if (byte_address !== AW'(n) || byte_data !== (8'(n) ^ 8'h5A)) bad++;
        sum = sum + (8'(n) ^ 8'h5A);
        last_a = int'(byte_address);
        n++;
      end
      if (done) dones++;
      if (busy && !done && (ip3601_selection_port !== s01_on || ip3604_selection_port !== s04_on)) bad_sel++;
      if (!busy && !done) break;
      step();
      cyc++;
    end
    checks++;
    if (cyc >= 6000) begin errors++; $display("FAIL dump%0d_timeout: ran %0d cycles without returning idle", ct, cyc); end
    checks++;
    if (rise0 !== AC + 3) begin errors++; $display("FAIL dump%0d_latency: first valid after %0d edges, expected %0d", ct, rise0, AC + 3); end
    checks++;
    if (rise1 - rise0 !== AC + 4) begin errors++; $display("FAIL dump%0d_period: %0d cycles, expected %0d", ct, rise1 - rise0, AC + 4); end
    checks++;
    if (n !== depth) begin errors++; $display("FAIL dump%0d_count: %0d transfers, expected %0d", ct, n, depth); end
    checks++;
    if (last_a !== depth - 1) begin errors++; $display("FAIL dump%0d_last_addr: %0d expected %0d", ct, last_a, depth - 1); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dump%0d_bytes: %0d wrong data/address, expected 0", ct, bad); end
    checks++;
    if (bad_sel !== 0) begin errors++; $display("FAIL dump%0d_selects: %0d bad select cycles, expected 0", ct, bad_sel); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL dump%0d_done: %0d pulses, expected 1", ct, dones); end
    checks++;
    if (checksum !== sum || checksum !== (ct ? 8'h00 : 8'h80)) begin
      errors++; $display("FAIL dump%0d_checksum: got %h expected %h", ct, checksum, sum);
    end
    checks++;
    if ({ip3601_selection_port, ip3604_selection_port} !== 6'b11_1111) begin
      errors++; $display("FAIL dump%0d_sel_idle: s01=%b s04=%b expected 11/1111", ct, ip3601_selection_port, ip3604_selection_port);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stall_bad;
    chip_type = 1'b1; byte_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_xfer(9, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL bp_reach9: got %b expected 1", ok); end
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 40 && !byte_valid; i++) step();
    checks++;
    if (byte_address !== 9'd10) begin errors++; $display("FAIL bp_addr: got %0d expected 10", byte_address); end
    stall_bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (byte_valid !== 1'b1 || byte_data !== 8'h50 || byte_address !== 9'd10 ||
          chip_address_port !== 9'd10 || checksum !== exp_sum(10)) stall_bad++;
      step();
    end
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", stall_bad); end
    byte_ready = 1'b1;
    step();
    checks++;
    if (byte_valid !== 1'b0 || checksum !== exp_sum(11)) begin
      errors++; $display("FAIL bp_release: valid=%b csum=%h expected 0/%h", byte_valid, checksum, exp_sum(11));
    end
  endtask

  task automatic test_abort();
    bit ok;
    int late;
    wait_xfer(99, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL abort_reach99: got %b expected 1", ok); end
    step();
    byte_ready = 1'b0;
    for (int i = 0; i < 40 && !byte_valid; i++) step();
    checks++;
    if (byte_address !== 9'd100) begin errors++; $display("FAIL abort_addr: got %0d expected 100", byte_address); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, byte_valid, ip3601_selection_port, ip3604_selection_port} !== 8'b00_11_1111) begin
      errors++; $display("FAIL abort_state: busy=%b valid=%b s01=%b s04=%b expected 0/0/11/1111",
                         busy, byte_valid, ip3601_selection_port, ip3604_selection_port);
    end
    checks++;
    if (checksum !== exp_sum(100)) begin errors++; $display("FAIL abort_checksum: got %h expected %h", checksum, exp_sum(100)); end
    late = 0;
    byte_ready = 1'b1;
    repeat (20) begin
      if (done || busy) late++;
      step();
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL abort_quiet: %0d cycles with done/busy, expected 0", late); end
  endtask

  task automatic test_start_abort();
    bit ok;
    int got;
    chip_type = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ip3601_selection_port !== 2'b11) begin
      errors++; $display("FAIL start_abort: busy=%b s01=%b expected 0/11", busy, ip3601_selection_port);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_later: busy=%b expected 0", busy); end
    byte_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_xfer(3, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL busy_reach3: got %b expected 1", ok); end
    start = 1'b1; chip_type = 1'b1;
    repeat (10) step();
    start = 1'b0; chip_type = 1'b0;
    got = -1;
    for (int i = 0; i < 40; i++) begin
      if (byte_valid && byte_ready) begin got = int'(byte_address); break; end
      step();
    end
    checks++;
    if (got !== 5) begin errors++; $display("FAIL start_while_busy: next address %0d expected 5", got); end
    checks++;
    if (ip3601_selection_port !== 2'b00 || ip3604_selection_port !== 4'b1111) begin
      errors++; $display("FAIL chip_type_ignored: s01=%b s04=%b expected 00/1111", ip3601_selection_port, ip3604_selection_port);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_abort: busy=%b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    bit ok;
    chip_type = 1'b0; byte_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_xfer(5, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rst_reach5: got %b expected 1", ok); end
    repeat (3) step();
    checks++;
    if (checksum !== exp_sum(6) || busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre: csum=%h busy=%b expected %h/1", checksum, busy, exp_sum(6));
    end
    #2;
    reset_button = 1'b0;
    #1;
    checks++;
    if ({busy, byte_valid, done, checksum, byte_data, byte_address} !== 28'd0) begin
      errors++; $display("FAIL rst_async_regs: busy=%b valid=%b done=%b csum=%h data=%h baddr=%h expected zeros",
                         busy, byte_valid, done, checksum, byte_data, byte_address);
    end
    checks++;
    if ({chip_address_port, ip3601_selection_port, ip3604_selection_port} !== {9'd0, 2'b11, 4'b1111}) begin
      errors++; $display("FAIL rst_async_pins: addr=%h s01=%b s04=%b expected 0/11/1111",
                         chip_address_port, ip3601_selection_port, ip3604_selection_port);
    end
    @(posedge clk);
    #3;
    reset_button = 1'b1;
    step();
    test_full_dump(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_dump(1'b1);
    test_full_dump(1'b0);
    test_backpressure();
    test_abort();
    test_start_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
